uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmit byte path (8-bit data, write enable, FIFO-full status) between NREQ requesters. Arbitration is round-robin at message granularity: a requester keeps the grant until it hands over a byte flagged last. A watchdog releases a grant when its owner stops supplying bytes mid-message. The block sits between the software- and hardware-side byte producers and the UART transmitter's FIFO write port.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 255, idle cycles a granted requester may withhold valid before its grant is revoked (must be at least 1)
TO_W, 8, width of the watchdog counter (2**TO_W > TIMEOUT)

Ports:
clk  in  1  system clock
RSTn  in  1  reset; asynchronous, active-low
req_valid  in  NREQ  per-requester byte valid
req_data  in  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i]
req_last  in  NREQ  byte is the final byte of the message
req_ready  out  NREQ  byte accepted this cycle (one-hot or zero)
uart_data  out  8  byte to the transmitter FIFO
uart_tx_en  out  1  FIFO write strobe
uart_full  in  1  transmitter FIFO full
grant  out  NREQ  one-hot current owner; zero when idle
busy  out  1  a grant is held
timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, grant=0, busy=0, timeout=0, watchdog=0, rr_ptr=NREQ-1 (requester 0 wins the first arbitration). All outputs deassert immediately while RSTn=0; a message in flight is abandoned with no flush.
- States: IDLE and GRANT.
- IDLE: if any req_valid is high, grant the first valid requester searching rr_ptr+1, rr_ptr+2, ... modulo NREQ. The grant register updates on the next edge (1-cycle arbitration latency); state becomes GRANT. No byte transfers while in IDLE.
- GRANT, owner g:
  - xfer = req_valid[g] & ~uart_full, computed combinationally.
  - uart_tx_en = xfer and req_ready[g] = xfer in the same cycle. Zero-latency pass-through: uart_data = req_data[g] whenever in GRANT, otherwise 8'h00.
  - Non-owners always see req_ready=0.
- Message end: on xfer & req_last[g], the next state is IDLE, rr_ptr<=g and the grant clears. This gives one bubble cycle before the next grant, even if requests are pending.
- Watchdog: counts cycles in GRANT with req_valid[g]=0.
  - Cleared on any cycle where req_valid[g]=1, whether stalled or transferring.
  - A cycle stalled by uart_full does not advance the counter.
  - When the count reaches TIMEOUT: next state is IDLE, rr_ptr<=g, grant clears, timeout=1 for exactly one cycle, counter clears.
  - A transfer in the same cycle takes priority: the counter clears and the grant is kept.
- uart_full held high: the owner stalls indefinitely and its grant is kept; no timeout.
- Owner's req_last arrives with req_valid=0: ignored, because only handshaked bytes count.
- A requester whose valid drops while it is not granted loses nothing; it is considered again at the next arbitration.
- busy = (state==GRANT).
- All state is registered; grant, busy and timeout come directly from flops.

Decomposition:
- Shared package: state encoding (IDLE, GRANT) and the default NREQ/TIMEOUT constants used by the peripheral top level.
- One natural sub-module: rr_arbiter_pick, combinational. Inputs are the request vector and rr_ptr; outputs are the one-hot winner and a found flag. It is reusable by other shared peripherals.
- Watchdog and FSM stay in the top module.

Test Plan:
- Single message: after reset, req 0 sends 3 bytes 8'hA1, 8'hA2, 8'hA3 (last on A3), uart_full=0 → grant=4'b0001 one cycle after valid; uart_tx_en high for 3 consecutive cycles carrying A1, A2, A3; grant=0 the cycle after A3.
- Round-robin fairness: req 1 and req 3 each continuously offer 1-byte messages → grants alternate 4'b0010, 4'b1000, 4'b0010, ..., with one idle cycle between grants.
- Atomicity: req 2 is granted on a 4-byte message; req 0 asserts valid after byte 1 → req_ready[0] stays 0 until req 2's last byte is accepted; req 0 is granted next.
- Backpressure: uart_full=1 for 300 cycles mid-message with owner valid high → uart_tx_en=0 and timeout never pulses; bytes resume in order after uart_full drops.
- Watchdog: owner sends 1 byte without last, then drops valid; TIMEOUT=255 → timeout pulses exactly 255 cycles later; grant=0 the same cycle; the next pending requester is granted one cycle after.
- Async reset mid-message: RSTn low between edges → uart_tx_en, grant and req_ready are 0 immediately; after release, requester 0 has first priority.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int UART_ARB_NREQ    = 4;
  localparam int UART_ARB_TIMEOUT = 255;
  localparam int UART_ARB_TO_W    = 8;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Round-robin pick: first set request after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; found=0 and gnt=0 when no request is set.
module rr_arbiter_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            found
);

  logic [PW-1:0] idx;

  // Scan ptr+1, ptr+2, ... and keep the first hit as the one-hot winner.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX byte path among NREQ requesters, round-robin per message, with a grant watchdog.
// Latency: 1 cycle to grant from IDLE; bytes pass through combinationally while granted.
// Backpressure: uart_full stalls the owner (req_ready=0, grant kept); non-owners always see req_ready=0.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ    = UART_ARB_NREQ,
  parameter int TIMEOUT = UART_ARB_TIMEOUT,
  parameter int TO_W    = UART_ARB_TO_W
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        uart_data,
  output logic              uart_tx_en,
  input  logic              uart_full,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout
);

  localparam int PW = $clog2(NREQ);

  arb_state_t      state, state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [TO_W-1:0] wd_cnt;

  logic [NREQ-1:0] pick_gnt;
  logic            pick_found;

  logic [PW-1:0]   owner_idx;
  logic            owner_valid;
  logic            owner_last;
  logic [7:0]      owner_data;

  logic            xfer;
  logic            msg_end;
  logic            wd_expire;
  logic            release_grant;

  rr_arbiter_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  // Select the current owner's handshake signals through the one-hot grant.
  always_comb begin
    owner_idx   = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        owner_idx   = PW'(i);
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[8*i +: 8];
      end
    end
  end

  // Only handshaked bytes count; the watchdog fires only on a cycle with no owner valid.
  assign xfer          = (state == ST_GRANT) && owner_valid && !uart_full;
  assign msg_end       = xfer && owner_last;
  assign wd_expire     = (state == ST_GRANT) && !owner_valid && (wd_cnt == TO_W'(TIMEOUT - 1));
  assign release_grant = msg_end || wd_expire;
  assign busy          = (state == ST_GRANT);

  // FSM state register.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: grant on any request, drop back to IDLE on message end or watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_found)    state_nxt = ST_GRANT;
      ST_GRANT: if (release_grant) state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: zero-latency pass-through of the owner's byte and handshake.
  always_comb begin
    req_ready  = '0;
    uart_tx_en = 1'b0;
    uart_data  = 8'h00;
    if (state == ST_GRANT) begin
      uart_data  = owner_data;
      uart_tx_en = xfer;
      req_ready  = xfer ? grant : '0;
    end
  end

  // Grant, round-robin pointer, watchdog counter and timeout pulse.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      grant   <= '0;
      rr_ptr  <= PW'(NREQ - 1);
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= wd_expire;
      if (state == ST_IDLE) begin
        grant  <= pick_gnt;
        wd_cnt <= '0;
      end else if (release_grant) begin
        grant  <= '0;
        rr_ptr <= owner_idx;
        wd_cnt <= '0;
      end else if (owner_valid) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule
